// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one step per cycle, then a sign-fix cycle.
//
// state  | meaning
// IDLE   | waiting; accepts MULT/DIV starts, MTHI/MTLO writes complete here
// MUL    | 32 shift-add steps, LSB-first over the multiplier
// DIV    | 32 restoring-divide steps, one quotient bit per step
// FIX    | sign correction and corner cases, write HI/LO, pulse done
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        is_signed;
  logic [31:0] x_mag, y_mag;

  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] rem;
  logic [31:0] x_orig;
  logic [4:0]  cnt;
  logic        neg_q, neg_r, zflag, is_div;

  logic [32:0] rem_sh, diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign accept    = (state == S_IDLE) && start && !flush;
  assign is_signed = ~op[0];
  assign x_mag     = (is_signed && x[31]) ? (~x + 32'd1) : x;
  assign y_mag     = (is_signed && y[31]) ? (~y + 32'd1) : y;
  assign busy      = (state != S_IDLE);

  // Partial remainder never exceeds the divisor, so a 33-bit subtract
  // leaves the borrow in bit 32.
  assign rem_sh = {rem, opa[31]};
  assign diff   = rem_sh - {1'b0, opb};

  assign prod_fix = neg_q ? (~acc + 64'd1) : acc;
  assign quot_fix = neg_q ? (~opa + 32'd1) : opa;
  assign rem_fix  = neg_r ? (~rem + 32'd1) : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && (op == 3'd0 || op == 3'd1)) state_nxt = S_MUL;
        if (accept && (op == 3'd2 || op == 3'd3)) state_nxt = S_DIV;
      end
      S_MUL:   if (cnt == 5'd31) state_nxt = S_FIX;
      S_DIV:   if (cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      opa      <= '0;
      opb      <= '0;
      rem      <= '0;
      x_orig   <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zflag    <= 1'b0;
      is_div   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              3'd0, 3'd1: begin
                mcand  <= {32'd0, x_mag};
                opb    <= y_mag;
                acc    <= '0;
                cnt    <= '0;
                neg_q  <= is_signed & (x[31] ^ y[31]);
                neg_r  <= 1'b0;
                zflag  <= 1'b0;
                is_div <= 1'b0;
              end
              3'd2, 3'd3: begin
                opa    <= x_mag;
                opb    <= y_mag;
                rem    <= '0;
                cnt    <= '0;
                neg_q  <= is_signed & (x[31] ^ y[31]);
                neg_r  <= is_signed & x[31];
                zflag  <= (y == 32'd0);
                x_orig <= x;
                is_div <= 1'b1;
              end
              3'd4:    hi <= x;
              3'd5:    lo <= x;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (opb[cnt]) acc <= acc + mcand;
          mcand <= mcand << 1;
          cnt   <= cnt + 5'd1;
        end
        S_DIV: begin
          if (diff[32]) begin
            rem <= rem_sh[31:0];
            opa <= {opa[30:0], 1'b0};
          end else begin
            rem <= diff[31:0];
            opa <= {opa[30:0], 1'b1};
          end
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          if (!flush) begin
            if (!is_div) begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end else if (zflag) begin
              hi <= x_orig;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
            div_zero <= is_div & zflag;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
